syscall_input_reader: RTL
=========================

Name: syscall_input_reader

Overview:
- Read-direction counterpart to the LED output path.
- When the CPU issues a syscall with the read service code in R1, the block stalls the CPU until the operator confirms with a debounced button press.
- It then samples the switch bank and returns the value for write-back into the syscall result register.
- Sits beside the LED data register, driven by the same Syscall/R1 decode signals.

Parameters:
- READ_CODE, 5: R1 service code that requests input.
- SW_WIDTH, 16: number of switch inputs, 1..32.
- DB_CYCLES, 16: consecutive cycles btn must stay high to count as a press, ≥2.

Ports:
- clk, input, 1: system clock, rising edge.
- clr, input, 1: asynchronous reset, active-low.
- Syscall, input, 1: current instruction is a syscall.
- R1_out, input, 32: register-file read port 1, the service code.
- sw, input, SW_WIDTH: raw switch levels, asynchronous.
- btn, input, 1: raw confirm button, asynchronous, active-high.
- stall, output, 1: freeze PC/pipeline while high.
- rdata, output, 32: captured switch value, zero-extended.
- wb_en, output, 1: one-cycle write-back strobe for rdata.
- busy, output, 1: FSM not in IDLE.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE, rdata=0, wb_en=0, busy=0.
  - Synchronizer flops and debounce counter cleared.
  - stall=0.
- Input synchronization:
  - btn passes through a 2-flop synchronizer (btn_s) and is visible 2 clk edges after the change.
  - sw is registered once (sw_r) before capture.
- req = Syscall & (R1_out == READ_CODE), combinational.
- stall is combinational: (state==IDLE & req) | state∈{WAIT_REL, WAIT_PRESS, DEBOUNCE}. It is 0 in DONE, so the stalled syscall retires that cycle.
- States and transitions:
  - IDLE: req → WAIT_REL. Otherwise stay.
  - WAIT_REL: btn_s==0 → WAIT_PRESS. This guarantees a button held from an earlier read is not reused.
  - WAIT_PRESS: btn_s==1 → DEBOUNCE, with cnt=1.
  - DEBOUNCE:
    - btn_s==0 → WAIT_PRESS, cnt=0 (bounce rejected).
    - btn_s==1 and cnt==DB_CYCLES-1 → rdata <= {zeros, sw_r}, go to DONE.
    - Otherwise cnt++.
  - DONE: wb_en=1 for exactly this cycle, then → IDLE unconditionally. req is not examined in DONE.
- The counter is sized $clog2(DB_CYCLES)+1 bits and never wraps, since it saturates by transition.
- rdata holds its value until the next capture. wb_en is a registered output, high only in DONE.
- busy = (state != IDLE).
- Boundaries:
  - req deasserting mid-wait (e.g. an interrupt flush): the FSM completes anyway. The CPU must not flush a stalled syscall.
  - A second read syscall immediately after DONE is a new request from IDLE and needs a fresh release and press.
  - clr asserted mid-operation aborts with no wb_en pulse.
  - A non-read syscall (R1≠READ_CODE) has no effect and never asserts stall.
  - With SW_WIDTH=32 there is no zero extension.
- Minimum latency from req to wb_en, with the button released then pressed cleanly: 1 (→WAIT_REL) + sync + DB_CYCLES + 1 cycles.

Decomposition:
- Shared package:
  - Syscall service-code constants: LED_WRITE=34, INPUT_READ=5.
  - State encoding localparams: IDLE=0, WAIT_REL=1, WAIT_PRESS=2, DEBOUNCE=3, DONE=4, 3 bits.
- One natural sub-module, btn_debouncer: synchronizer plus counter. It outputs a one-cycle press pulse and the level btn_s.
- The FSM and capture register stay in the top module.
- The existing generic register module can hold rdata, with enable = capture condition.

Test Plan:
- Reset: clr=0 mid-DEBOUNCE → stall=0, busy=0, rdata=0, wb_en=0 immediately; no wb_en after clr=1.
- Clean read (DB_CYCLES=4):
  - Stimulus: Syscall=1, R1=5, sw=16'hA5C3, btn low 3 cycles, then high 6 cycles.
  - Expected: stall high from the first cycle; single wb_en with rdata=32'h0000A5C3; stall=0 in the wb_en cycle; busy=0 next cycle.
- Bounce rejection: btn high 2 cycles, low 1, high 5 (DB_CYCLES=4) → capture only after the second high run. wb_en occurs exactly once, and rdata is the sw value at that capture.
- Held button: btn already high when req arrives → no capture until btn goes low then high ≥4 cycles; stall high throughout.
- Wrong code: Syscall=1, R1=34, btn toggling → stall=0, busy=0, wb_en never asserted, rdata unchanged.
- Back-to-back: two read syscalls with sw=16'h0001 then 16'hFFFF → two wb_en pulses, rdata 32'h00000001 then 32'h0000FFFF. Each requires a distinct release/press.

Source files
------------

// File: rtl/syscall_input_reader_pkg.sv
// rtl/syscall_input_reader_pkg.sv - service codes and FSM state encoding for the syscall input reader
package syscall_input_reader_pkg;

  // Syscall service codes carried in R1
  localparam logic [31:0] LED_WRITE  = 32'd34;
  localparam logic [31:0] INPUT_READ = 32'd5;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_REL   = 3'd1,
    WAIT_PRESS = 3'd2,
    DEBOUNCE   = 3'd3,
    DONE       = 3'd4
  } rd_state_t;

endpackage

// File: rtl/syscall_input_reader_if.sv
// rtl/syscall_input_reader_if.sv - CPU-side syscall decode and write-back bundle
// Syscall/R1_out come from the CPU decode stage; stall/rdata/wb_en/busy go back to it.
interface syscall_input_reader_if;
  logic        Syscall;
  logic [31:0] R1_out;
  logic        stall;
  logic [31:0] rdata;
  logic        wb_en;
  logic        busy;

  modport master (output Syscall, R1_out, input stall, rdata, wb_en, busy);
  modport slave  (input Syscall, R1_out, output stall, rdata, wb_en, busy);
endinterface

// File: rtl/syscall_input_reader_btn_debouncer.sv
// rtl/syscall_input_reader_btn_debouncer.sv - button synchronizer and press-length counter
// Ports: clk, clr (async active-low), btn (raw), arm (count enable from FSM),
//        btn_s (synchronized level), press (one-cycle pulse on DB_CYCLES-th high sample).
module syscall_input_reader_btn_debouncer #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic btn,
  input  logic arm,
  output logic btn_s,
  output logic press
);

  localparam int            CW   = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          btn_m;
  logic [CW-1:0] cnt;

  // The first high sample seen while armed counts as 1, so press fires on the
  // DB_CYCLES-th consecutive high sample; the counter clears before it can wrap.
  assign press = arm & btn_s & (cnt == LAST);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      cnt   <= '0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      if (!arm || !btn_s || press) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/syscall_input_reader.sv
// rtl/syscall_input_reader.sv - stalls a read syscall until a debounced button press, then returns the switches
// Ports: clk, clr (async active-low), cpu (slave: Syscall, R1_out in; stall, rdata, wb_en, busy out),
//        sw (raw switches), btn (raw confirm button, active-high).
module syscall_input_reader
  import syscall_input_reader_pkg::*;
#(
  parameter logic [31:0] READ_CODE = INPUT_READ,
  parameter int          SW_WIDTH  = 16,
  parameter int          DB_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  syscall_input_reader_if.slave cpu,
  input  logic [SW_WIDTH-1:0]   sw,
  input  logic                  btn
);

  rd_state_t           state;
  logic [SW_WIDTH-1:0] sw_r;
  logic [31:0]         rdata_q;
  logic                wb_q;
  logic                req;
  logic                arm;
  logic                btn_s;
  logic                press;

  assign req = cpu.Syscall & (cpu.R1_out == READ_CODE);
  assign arm = (state == WAIT_PRESS) | (state == DEBOUNCE);

  syscall_input_reader_btn_debouncer #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db (
    .clk  (clk),
    .clr  (clr),
    .btn  (btn),
    .arm  (arm),
    .btn_s(btn_s),
    .press(press)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sw_r <= '0;
    end else begin
      sw_r <= sw;
    end
  end

  // wb_en is registered and high only while in DONE; rdata holds until the next capture.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      rdata_q <= '0;
      wb_q    <= 1'b0;
    end else begin
      wb_q <= 1'b0;
      case (state)
        IDLE:       if (req) state <= WAIT_REL;
        // A button still held from an earlier read must be released first.
        WAIT_REL:   if (!btn_s) state <= WAIT_PRESS;
        WAIT_PRESS: if (btn_s) state <= DEBOUNCE;
        DEBOUNCE: begin
          if (!btn_s) begin
            state <= WAIT_PRESS;
          end else if (press) begin
            rdata_q <= 32'(sw_r);
            wb_q    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:       state <= IDLE;
        default:    state <= IDLE;
      endcase
    end
  end

  // Stall is dropped in DONE so the syscall retires on the write-back cycle;
  // gating with clr keeps it low while reset is held even if a request is present.
  assign cpu.stall = clr & (((state == IDLE) & req) | (state == WAIT_REL) | arm);
  assign cpu.busy  = (state != IDLE);
  assign cpu.rdata = rdata_q;
  assign cpu.wb_en = wb_q;

endmodule
